// File: rtl/fb_arbiter.sv
// Frame-buffer access controller: shares one pixel RAM between scan-out reads and blitter writes,
// with tear-free page flipping on frame boundaries. Define FB_DOUBLE_BUFFER_EN for two-bank operation.
module fb_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 24,
    parameter int WAIT_MAX = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              frame_end,
    input  logic              flip_req,
    output logic              flip_done,
    output logic              front_bank,
    output logic              wr_starved,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SWAP  = 2'd2
    } flip_state_t;

    flip_state_t      flip_state;
    logic [1:0]       rd_pipe;
    logic [CNT_W-1:0] wait_cnt;
    logic             rd_grant;
    logic             wr_grant;
    logic             wr_stall;
    logic             rd_bank;
    logic             wr_bank;

`ifdef FB_DOUBLE_BUFFER_EN
    assign wr_stall = (flip_state == ARMED);
    assign rd_bank  = front_bank;
    assign wr_bank  = ~front_bank;
`else
    assign wr_stall = 1'b0;
    assign rd_bank  = 1'b0;
    assign wr_bank  = 1'b0;
`endif

    // Blocking the grant while wr_ack is high stops a held request being written twice.
    assign rd_grant = rd_req;
    assign wr_grant = !rd_req && wr_req && !wr_ack && !wr_stall;

    // NOTE: all state below uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            wr_ack    <= 1'b0;
            rd_pipe   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            ram_we <= wr_grant;
            wr_ack <= wr_grant;
            if (rd_grant) begin
                ram_addr <= {rd_bank, rd_addr};
            end else if (wr_grant) begin
                ram_addr  <= {wr_bank, wr_addr};
                ram_wdata <= wr_data;
            end
            // Stage 0: address on RAM; stage 1: RAM data present; then registered out.
            rd_pipe  <= {rd_pipe[0], rd_grant};
            rd_valid <= rd_pipe[1];
            if (rd_pipe[1]) begin
                rd_data <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            flip_state <= IDLE;
            flip_done  <= 1'b0;
            front_bank <= 1'b0;
        end else begin
            flip_done <= 1'b0;
            case (flip_state)
                IDLE: begin
                    // A frame_end coinciding with flip_req is not counted.
                    if (flip_req) begin
                        flip_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (frame_end) begin
                        flip_state <= SWAP;
                        flip_done  <= 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
                        front_bank <= ~front_bank;
`endif
                    end
                end
                SWAP:    flip_state <= IDLE;
                default: flip_state <= IDLE;
            endcase
        end
    end

    // Deliberate ARMED stalls are not starvation, so the count holds through them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt   <= '0;
            wr_starved <= 1'b0;
        end else if (!wr_req || wr_grant) begin
            wait_cnt <= '0;
        end else if (!wr_stall && wait_cnt != CNT_W'(WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                wr_starved <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed reset/read/write/starvation/flip steps, then randomized traffic
// checked against a transaction-level model (pixel array plus expected-read queue).
module tb_fb_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 24;
    localparam int WAIT_MAX = 64;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              frame_end;
    logic              flip_req;
    logic              flip_done;
    logic              front_bank;
    logic              wr_starved;
    logic [ADDR_W:0]   ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .frame_end(frame_end), .flip_req(flip_req), .flip_done(flip_done),
        .front_bank(front_bank), .wr_starved(wr_starved),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        logic [31:0] v;
        v = (a * 32'h0001_0203) ^ 32'h005A_5A5A;
        return (a == 32'h41) ? 24'hAABBCC : v[DATA_W-1:0];
    endfunction

    // Single-port synchronous RAM: data for the address presented in one cycle appears the next.
    logic [DATA_W-1:0] ram_mem [0:8191];
    logic              ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 8192; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    rd_exp_t           rq[$];
    logic [DATA_W-1:0] model_mem [0:8191];
    logic              exp_bank;
    logic              exp_ack;
    logic              exp_gnt;
    logic              exp_starved;
    logic              gnt_w;
    logic              vexp;
    logic              rb;
    logic              wb;
    logic [ADDR_W:0]   exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    int                wcnt;
    int                rd_pct;

    initial begin
        for (int i = 0; i < 8192; i++) model_mem[i] = init_word(i);
        exp_bank  = 1'b0;
        resetn    = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        frame_end = 1'b0;
        flip_req  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_front_bank", front_bank, 0);
        check("rst_flip_done", flip_done, 0);
        check("rst_starved", wr_starved, 0);
        resetn = 1'b1;
        tick();

        // Single read, latency 3
        rd_req  = 1'b1;
        rd_addr = 12'h041;
        tick();
        rd_req = 1'b0;
        check("rd_ram_addr", ram_addr, 13'h0041);
        check("rd_ram_we", ram_we, 0);
        check("rd_valid_t1", rd_valid, 0);
        tick();
        check("rd_valid_t2", rd_valid, 0);
        tick();
        check("rd_valid_t3", rd_valid, 1);
        check("rd_data_t3", rd_data, 24'hAABBCC);
        tick();
        check("rd_valid_t4", rd_valid, 0);

        // Single write; held request re-granted at t+2 at the earliest
        wr_req  = 1'b1;
        wr_addr = 12'h005;
        wr_data = 24'h123456;
        tick();
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, {DB, 12'h005});
        check("wr_ram_wdata", ram_wdata, 24'h123456);
        check("wr_ack_t1", wr_ack, 1);
        tick();
        check("wr_ack_t2", wr_ack, 0);
        check("wr_ram_we_t2", ram_we, 0);
        tick();
        check("wr_ack_t3", wr_ack, 1);
        wr_req = 1'b0;
        tick();
        check("wr_ack_t4", wr_ack, 0);

        // Reads saturate the port: writer starves
        for (int i = 0; i < 70; i++) begin
            rd_req  = 1'b1;
            rd_addr = 12'(i);
            wr_req  = 1'b1;
            tick();
            check("starve_no_ack", wr_ack, 0);
            check("starve_flag", wr_starved, (i + 1 >= WAIT_MAX) ? 1 : 0);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("starve_sticky", wr_starved, 1);

        // Reset with a read in flight
        rd_req  = 1'b1;
        rd_addr = 12'h041;
        tick();
        rd_req = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rst2_starved", wr_starved, 0);
        check("rst2_rd_valid_a", rd_valid, 0);
        tick();
        check("rst2_rd_valid_b", rd_valid, 0);
        tick();
        check("rst2_rd_valid_c", rd_valid, 0);

        // Flip with writer active; flip_req lands in a cycle where wr_ack is high
        wr_req  = 1'b1;
        wr_addr = 12'h005;
        wr_data = 24'hFEDCBA;
        tick();
        check("flip_pre_ack", wr_ack, 1);
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check("flip_armed_ack", wr_ack, DB ? 0 : ((k % 2 == 0) ? 1 : 0));
            check("flip_armed_done", flip_done, 0);
            check("flip_armed_bank", front_bank, exp_bank);
            if (k == 10) frame_end = 1'b1;
            tick();
        end
        frame_end = 1'b0;
        exp_bank  = exp_bank ^ DB;
        check("flip_done", flip_done, 1);
        check("flip_bank", front_bank, exp_bank);
        check("flip_swap_ack", wr_ack, 0);
        tick();
        wr_req = 1'b0;
        check("flip_post_ack", wr_ack, 1);
        check("flip_post_addr", ram_addr, 13'h0005);
        check("flip_done_clear", flip_done, 0);
        tick();

        // flip_req and frame_end together: swap waits for the next frame_end
        flip_req  = 1'b1;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("sim_no_done_a", flip_done, 0);
        tick();
        flip_req = 1'b0;
        check("sim_no_done_b", flip_done, 0);
        tick();
        check("sim_no_done_c", flip_done, 0);
        check("sim_bank_hold", front_bank, exp_bank);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        exp_bank  = exp_bank ^ DB;
        check("sim_done", flip_done, 1);
        check("sim_bank", front_bank, exp_bank);
        // flip_req during SWAP is ignored, so the next frame_end does nothing
        flip_req = 1'b1;
        tick();
        flip_req  = 1'b0;
        frame_end = 1'b1;
        check("swap_req_done", flip_done, 0);
        tick();
        frame_end = 1'b0;
        tick();
        check("swap_req_ignored", flip_done, 0);
        check("swap_req_bank", front_bank, exp_bank);
        tick();

        // Randomized traffic against the transaction model
        exp_ack     = 1'b0;
        exp_gnt     = 1'b0;
        exp_starved = 1'b0;
        wcnt        = 0;
        for (int n = 0; n < 500; n++) begin
            check("rnd_wr_ack", wr_ack, exp_ack);
            check("rnd_ram_we", ram_we, exp_ack);
            if (exp_gnt) check("rnd_ram_addr", ram_addr, exp_addr);
            if (exp_ack) check("rnd_ram_wdata", ram_wdata, exp_wdata);
            vexp = (rq.size() > 0) && (rq[0].due == cyc);
            check("rnd_rd_valid", rd_valid, vexp);
            if (vexp) begin
                check("rnd_rd_data", rd_data, rq[0].data);
                void'(rq.pop_front());
            end
            check("rnd_starved", wr_starved, exp_starved);
            check("rnd_front_bank", front_bank, exp_bank);

            rd_pct = (n < 300) ? 40 : 97;
            if (!wr_req || wr_ack) begin
                wr_req  = ($urandom_range(0, 2) != 0);
                wr_addr = 12'h100 + 12'($urandom_range(0, 15));
                wr_data = DATA_W'($urandom);
            end
            rd_req  = ($urandom_range(0, 99) < rd_pct);
            rd_addr = 12'h100 + 12'($urandom_range(0, 15));
            if (n >= 495) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end

            rb      = DB & exp_bank;
            wb      = DB & ~exp_bank;
            exp_gnt = 1'b0;
            gnt_w   = 1'b0;
            if (rd_req) begin
                exp_addr = {rb, rd_addr};
                exp_gnt  = 1'b1;
                rq.push_back('{cyc + 3, model_mem[{rb, rd_addr}]});
            end else if (wr_req && !exp_ack) begin
                gnt_w     = 1'b1;
                exp_gnt   = 1'b1;
                exp_addr  = {wb, wr_addr};
                exp_wdata = wr_data;
                model_mem[{wb, wr_addr}] = wr_data;
            end
            if (!wr_req || gnt_w) wcnt = 0;
            else if (wcnt < WAIT_MAX) wcnt++;
            if (wcnt == WAIT_MAX) exp_starved = 1'b1;
            exp_ack = gnt_w;
            tick();
        end
        check("rnd_queue_drained", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Frame-buffer access controller for the 64x64 HUB75 LED panel path. It shares one single-port synchronous pixel RAM between two requesters. The scan-out reader (driven by the panel scanner) has strict priority. The pixel writer (sprite/host blitter) uses a request/ack handshake. The block also performs tear-free page flipping between two RAM banks on frame boundaries, and sits between the scanner/sprite generators and the pixel RAM.

## Interface
- ADDR_W, 12, pixel address width per bank (64x64)
- DATA_W, 24, pixel word width ({b,g,r} 8 bits each)
- WAIT_MAX, 64, consecutive starved writer cycles before `wr_starved` sets

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- rd_req  in  1  scan-out read request, one cycle per pixel
- rd_addr  in  ADDR_W  scan-out pixel address
- rd_data  out  DATA_W  read pixel
- rd_valid  out  1  `rd_data` valid strobe
- wr_req  in  1  write request; held with stable addr/data until `wr_ack`
- wr_addr  in  ADDR_W  write address (back bank)
- wr_data  in  DATA_W  write pixel
- wr_ack  out  1  one-cycle pulse: write performed
- frame_end  in  1  one-cycle pulse from scanner at end of frame
- flip_req  in  1  one-cycle pulse: writer finished, swap banks
- flip_done  out  1  one-cycle pulse: swap taken effect
- front_bank  out  1  bank currently displayed
- wr_starved  out  1  sticky starvation flag
- ram_addr  out  ADDR_W+1  {bank, addr} to RAM
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- Reset: all outputs 0, including `front_bank`=0 (writer targets bank 1) and `wr_starved`=0. Flip FSM goes to IDLE and the read pipeline is flushed.
- Arbitration is evaluated every cycle on sampled inputs:
  - `rd_req`=1: read granted, bank = `front_bank` at that cycle.
  - Else, a write is granted when `wr_req`=1, `wr_ack`=0 and the FSM is not ARMED. Bank = ~`front_bank`.
  - Else, RAM is idle (`ram_we`=0, `ram_addr` holds).
- The no-grant-while-`wr_ack` rule prevents a double write; peak write rate is 1 per 2 cycles.
- Read bank is captured at grant, so reads in flight across a swap return old-bank data.
- Flip FSM:
  - IDLE: `flip_req` -> ARMED.
  - ARMED: writes are stalled; `frame_end` -> SWAP.
  - SWAP (one cycle): toggle `front_bank`, pulse `flip_done` -> IDLE.
- Simultaneous events:
  - `flip_req` and `frame_end` in the same cycle while IDLE: go to ARMED; that `frame_end` is not counted, so the swap happens at the next one.
  - `flip_req` while ARMED or SWAP is ignored.
- Starvation counter:
  - Increments each cycle `wr_req`=1 and the write is not granted while not ARMED.
  - Clears on grant or when `wr_req`=0; saturates at WAIT_MAX.
  - Reaching WAIT_MAX sets `wr_starved`, which stays set until reset.
- Reset mid-operation discards in-flight reads (no `rd_valid`) and pending flips.

## Timing
- Read: `rd_req` sampled at cycle t -> `ram_addr` registered in t+1 -> `ram_rdata` in t+2 -> `rd_data`/`rd_valid` registered in t+3. Fixed latency 3; full throughput of 1 read/cycle.
- Write: granted at t -> `ram_we`, `ram_addr`, `ram_wdata`, `wr_ack` all high in t+1 (single cycle).
- Flip: `frame_end` at t in ARMED -> `front_bank` toggled and `flip_done`=1 in t+1. The first read using the new bank is one sampled at t+1.
- `rd_valid` is never suppressed by writes. The scanner must leave idle cycles (blank/latch) for writes to progress.

## Configuration
- `FB_DOUBLE_BUFFER_EN` defined: two banks, behaviour as above.
- Not defined: single bank.
  - `ram_addr` MSB is tied 0 and `front_bank` is tied 0.
  - The FSM still pulses `flip_done` one cycle after the first `frame_end` following `flip_req`, usable as a vsync handshake.
  - ARMED does not stall writes.

## Test plan
- Reset release, `rd_req` at t with `rd_addr`=0x041 and RAM model returning 0xAABBCC -> `ram_addr`=0x041 (bank 0) in t+1; `rd_data`=0xAABBCC with `rd_valid`=1 in t+3.
- `wr_req` with `wr_addr`=0x005, `wr_data`=0x123456 and no reads -> `ram_we`=1 and `ram_addr`=0x1005 in t+1; `wr_ack` pulses once; held `wr_req` is re-granted no earlier than t+2.
- `rd_req` continuously for 70 cycles with `wr_req` high -> no `wr_ack`; `wr_starved`=1 after 64 cycles; it stays 1 after the reads stop, until `resetn`=0.
- `flip_req` at t, `frame_end` at t+10 with `wr_req` high throughout -> no `wr_ack` in t+1..t+11; `front_bank`=1 and `flip_done`=1 in t+11; the following write hits `ram_addr` MSB 0.
- `flip_req` and `frame_end` in the same cycle -> no swap; swap occurs the cycle after the next `frame_end`.
- Build without `FB_DOUBLE_BUFFER_EN`: repeat the flip test -> `front_bank` stays 0, `ram_addr` MSB always 0, writes are not stalled, and `flip_done` still pulses in t+11.
